reg_writeback_file: RTL
=======================

# reg_writeback_file

Register file and writeback scoreboard at the consuming end of the register track selector. It takes the R1/R2 read addresses and RW write address produced for each issued instruction. It returns operand data with same-cycle writeback bypass, and queues destination addresses until out-of-order-latency results arrive in order. It stalls issue on read-after-write hazards and on a full pending-write queue.

## Interface
Parameters:
- WIDTH, 8, data width of each of the 4 registers
- DEPTH, 4, pending-write queue depth (power of 2, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- issue_valid  in  1  instruction presented for issue
- issue_ready  out  1  issue accepted when issue_valid && issue_ready (issue fire)
- track_select  in  1  1 = read-only instruction (rw_addr ignored); 0 = instruction writes rw_addr
- r1_addr  in  2  first source register
- r2_addr  in  2  second source register
- rw_addr  in  2  destination register (valid when track_select=0)
- r1_data  out  WIDTH  operand for r1_addr, combinational, with bypass
- r2_data  out  WIDTH  operand for r2_addr, combinational, with bypass
- wb_valid  in  1  result for oldest pending write is present
- wb_data  in  WIDTH  result value
- wb_ready  out  1  queue non-empty; wb fire = wb_valid && wb_ready
- pending_count  out  $clog2(DEPTH)+1  entries in pending-write queue
- wb_error  out  1  sticky: wb_valid seen while queue empty

## Operation
- State: regs[0..3] (WIDTH each); FIFO of DEPTH 2-bit destination addresses (head = oldest); busy[0..3] counters (0..DEPTH), busy[r] = queue entries targeting r; wb_error flag.
- Reset: regs all 0, FIFO empty, busy all 0, wb_error 0. Outputs after reset: issue_ready 1, r1_data/r2_data 0, wb_ready 0, pending_count 0, wb_error 0.
- Retire: on wb fire, regs[head] <= wb_data, pop head, busy[head] decrements.
- Bypass: rN_data = wb_data if wb fire && head == rN_addr; else regs[rN_addr].
- Effective busy: eb[r] = busy[r] − (wb fire && head == r ? 1 : 0).
- Hazard: hz = eb[r1_addr] != 0 || eb[r2_addr] != 0. Checked regardless of track_select.
- Full stall: fs = track_select == 0 && pending_count == DEPTH && !wb fire.
- issue_ready = !hz && !fs. Combinational; depends on wb_valid in the same cycle.
- Issue fire with track_select=0: push rw_addr at tail, busy[rw_addr] increments. Issue fire with track_select=1: no queue/busy change.
- Same-cycle push and pop: pending_count unchanged. If rw_addr == head, busy[head] is unchanged (+1−1).
- WAW: multiple pending writes to one register are allowed; busy counts them; retire order = issue order.
- wb_valid when queue empty: ignored (no register write), wb_error set until rst.
- Reset mid-operation: all pending writes discarded, registers zeroed; results arriving afterwards raise wb_error.

## Timing
- Reads: zero-latency combinational from addresses/regs/bypass.
- Retired value visible via bypass in the retire cycle; from regs the next cycle onward.
- Issue fire updates FIFO/busy/pending_count at the next edge; a dependent instruction in the following cycle sees hz = 1.
- Minimum issue-to-dependent-issue: 1 cycle after the producer's wb fire, or the same cycle as it via bypass.
- pending_count, wb_ready, and wb_error are registered-state derived; wb_error rises the cycle after the offending wb_valid.

## Test plan
- Reset then read: rst 1 cycle; r1_addr=2, r2_addr=3 -> r1_data=0, r2_data=0, issue_ready=1, pending_count=0, wb_ready=0.
- Write then dependent read: issue ts=0 rw=1 (r1=0,r2=0); next cycle issue ts=1 r1=1 -> issue_ready=0. Hold until wb_valid with wb_data=8'h5A -> that cycle issue_ready=1 and r1_data=8'h5A; next cycle regs[1]=8'h5A, pending_count=0.
- Full queue: DEPTH=4; issue 4 writes to reg 3 with no wb -> pending_count=4, busy[3]=4. 5th write issue (r1=0,r2=0) -> issue_ready=0. Same request with wb_valid=1 and head=3: accept requires r1/r2 ≠ 3 -> issue_ready=1, pending_count stays 4.
- In-order retire, WAW: issue writes to 2, 0, 2; wb_data 11, 22, 33 on consecutive cycles -> regs[2]=33, regs[0]=22, reading r2 stalls until the third retire.
- Spurious writeback: empty queue, wb_valid=1 wb_data=FF -> regs unchanged, wb_error=1 next cycle and stays 1 until rst.
- Reset mid-flight: 3 pending writes, assert rst -> pending_count=0, all regs 0, issue_ready=1; a following wb_valid sets wb_error.

Source files
------------

// File: rtl/reg_writeback_file_if.sv
// Issue/writeback bundle between the register track selector and the
// register writeback file.
interface reg_writeback_file_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             issue_valid;
    logic             issue_ready;
    logic             track_select;
    logic [1:0]       r1_addr;
    logic [1:0]       r2_addr;
    logic [1:0]       rw_addr;
    logic [WIDTH-1:0] r1_data;
    logic [WIDTH-1:0] r2_data;
    logic             wb_valid;
    logic [WIDTH-1:0] wb_data;
    logic             wb_ready;
    logic [CNT_W-1:0] pending_count;
    logic             wb_error;

    modport master (
        output issue_valid, track_select, r1_addr, r2_addr, rw_addr, wb_valid, wb_data,
        input  issue_ready, r1_data, r2_data, wb_ready, pending_count, wb_error
    );

    modport slave (
        input  issue_valid, track_select, r1_addr, r2_addr, rw_addr, wb_valid, wb_data,
        output issue_ready, r1_data, r2_data, wb_ready, pending_count, wb_error
    );
endinterface

// File: rtl/reg_writeback_file.sv
// Four-entry register file with an in-order pending-write queue, same-cycle
// writeback bypass and issue stalling on RAW hazards or a full queue.
module reg_writeback_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_writeback_file_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    logic [WIDTH-1:0] regs_r [4];
    logic [1:0]       fifo_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] busy_r [4];
    logic             wb_error_r;

    logic             wb_fire_s;
    logic             push_s;
    logic             hz_s;
    logic             fs_s;
    logic             issue_ready_s;
    logic [1:0]       head_addr_s;
    logic [CNT_W-1:0] eb1_s;
    logic [CNT_W-1:0] eb2_s;
    logic [WIDTH-1:0] r1_data_s;
    logic [WIDTH-1:0] r2_data_s;

    assign head_addr_s = fifo_r[head_r];
    assign wb_fire_s   = bus.wb_valid && (count_r != ZERO_CNT);

    // Operand bypass, effective busy (retiring write no longer counts) and issue gating
    always_comb begin
        if (wb_fire_s && (head_addr_s == bus.r1_addr)) begin
            r1_data_s = bus.wb_data;
            eb1_s     = busy_r[bus.r1_addr] - ONE_CNT;
        end else begin
            r1_data_s = regs_r[bus.r1_addr];
            eb1_s     = busy_r[bus.r1_addr];
        end
        if (wb_fire_s && (head_addr_s == bus.r2_addr)) begin
            r2_data_s = bus.wb_data;
            eb2_s     = busy_r[bus.r2_addr] - ONE_CNT;
        end else begin
            r2_data_s = regs_r[bus.r2_addr];
            eb2_s     = busy_r[bus.r2_addr];
        end
        hz_s          = (eb1_s != ZERO_CNT) || (eb2_s != ZERO_CNT);
        fs_s          = !bus.track_select && (count_r == FULL_CNT) && !wb_fire_s;
        issue_ready_s = !hz_s && !fs_s;
        push_s        = bus.issue_valid && issue_ready_s && !bus.track_select;
    end

    // Register array: retiring result lands in the head destination
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                regs_r[r] <= {WIDTH{1'b0}};
            end
        end else if (wb_fire_s) begin
            regs_r[head_addr_s] <= bus.wb_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Pending-write queue storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= ZERO_CNT;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= 2'b00;
            end
        end else begin
            if (push_s) begin
                fifo_r[tail_r] <= bus.rw_addr;
                tail_r         <= tail_r + ONE_PTR;
            end else begin
                tail_r <= tail_r;
            end
            if (wb_fire_s) begin
                head_r <= head_r + ONE_PTR;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, wb_fire_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Per-register count of outstanding writes; push and pop to one register cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                busy_r[r] <= ZERO_CNT;
            end
        end else begin
            for (int r = 0; r < 4; r++) begin
                case ({push_s && (bus.rw_addr == 2'(r)), wb_fire_s && (head_addr_s == 2'(r))})
                    2'b10:   busy_r[r] <= busy_r[r] + ONE_CNT;
                    2'b01:   busy_r[r] <= busy_r[r] - ONE_CNT;
                    default: busy_r[r] <= busy_r[r];
                endcase
            end
        end
    end

    // Sticky flag for results arriving with nothing pending
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_error_r <= 1'b0;
        end else if (bus.wb_valid && (count_r == ZERO_CNT)) begin
            wb_error_r <= 1'b1;
        end else begin
            wb_error_r <= wb_error_r;
        end
    end

    assign bus.issue_ready   = issue_ready_s;
    assign bus.r1_data       = r1_data_s;
    assign bus.r2_data       = r2_data_s;
    assign bus.wb_ready      = (count_r != ZERO_CNT);
    assign bus.pending_count = count_r;
    assign bus.wb_error      = wb_error_r;
endmodule
